// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// The slave modport is the loader; the master modport is the stream source / memory side.
interface imem_loader_if #(parameter int WIDTH = 5);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             reload;
    logic             we;
    logic [WIDTH-1:0] waddr;
    logic [31:0]      wdata;
    logic             cpu_hold;
    logic             done;
    logic             err;

    modport slave (
        input  in_data, in_valid, reload,
        output in_ready, we, waddr, wdata, cpu_hold, done, err
    );

    modport master (
        output in_data, in_valid, reload,
        input  in_ready, we, waddr, wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: framed bytes (LEN, 4*LEN data bytes LSB first, XOR checksum)
// are packed into 32-bit words and written at ascending addresses; CPU is held until a clean frame.
module imem_loader #(
    parameter int WIDTH = 5
) (
    input  logic          clk,
    input  logic          CLR_n,
    imem_loader_if.slave  bus
);
    localparam int LW = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, DATA, CSUM, DONE} state_t;

    state_t           state_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    wcnt_q;
    logic [1:0]       idx_q;
    logic [7:0]       xor_q;
    logic [23:0]      word_q;
    logic             we_q;
    logic [WIDTH-1:0] waddr_q;
    logic [31:0]      wdata_q;
    logic             hold_q;
    logic             done_q;
    logic             err_q;
    logic             rdy_q;

    logic accept;
    logic len_ok;

    assign accept = bus.in_valid & rdy_q;
    // Word count must be 1..2**WIDTH; compare at 32 bits so any WIDTH up to 30 works.
    assign len_ok = (bus.in_data != 8'd0) &&
                    ({24'd0, bus.in_data} <= (32'd1 << WIDTH));

    always_ff @(posedge clk) begin
        if (!CLR_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            idx_q   <= 2'd0;
            xor_q   <= 8'd0;
            word_q  <= 24'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        err_q <= !len_ok;
                        if (len_ok) begin
                            len_q   <= LW'(bus.in_data);
                            wcnt_q  <= '0;
                            idx_q   <= 2'd0;
                            xor_q   <= 8'd0;
                            waddr_q <= '0;
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        xor_q <= xor_q ^ bus.in_data;
                        idx_q <= idx_q + 2'd1;
                        case (idx_q)
                            2'd0: word_q[7:0]   <= bus.in_data;
                            2'd1: word_q[15:8]  <= bus.in_data;
                            2'd2: word_q[23:16] <= bus.in_data;
                            default: begin
                                // Top lane goes straight to the write port; no need to stage it.
                                we_q    <= 1'b1;
                                wdata_q <= {bus.in_data, word_q};
                                waddr_q <= wcnt_q[WIDTH-1:0];
                                wcnt_q  <= wcnt_q + 1'b1;
                                if (wcnt_q + 1'b1 == len_q)
                                    state_q <= CSUM;
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (bus.in_data == xor_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                            rdy_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.reload) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        hold_q  <= 1'b1;
                        rdy_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = rdy_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.cpu_hold = hold_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
